// File: rtl/hn_line_sequencer_if.sv
// ---------------------------------------------------------------------------
// hn_line_sequencer_if
//
// Bundles the two buses around the line sequencer:
//   - host stream : s_data, s_valid (host -> sequencer), s_ready (sequencer -> host)
//   - buffer port : wraddress, data, wren, rden, rdaddress (sequencer -> buffer),
//                   PrnData (buffer read data {H4,H3,H2,H1} -> sequencer)
//
// Modports:
//   master : the environment side (host data path + HnData_Ctrl buffer)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface hn_line_sequencer_if;
    logic [3:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [9:0] wraddress;
    logic [3:0] data;
    logic       wren;
    logic       rden;
    logic [9:0] rdaddress;
    logic [3:0] PrnData;

    modport master (
        output s_data, s_valid, PrnData,
        input  s_ready, wraddress, data, wren, rden, rdaddress
    );

    modport slave (
        input  s_data, s_valid, PrnData,
        output s_ready, wraddress, data, wren, rden, rdaddress
    );
endinterface

// File: rtl/hn_line_sequencer.sv
// ---------------------------------------------------------------------------
// hn_line_sequencer
//
// Loads one print line of 4-bit head nibbles from a valid/ready stream into
// the HnData_Ctrl buffer (addresses 0..WR_LEN-1), then on line_go sweeps the
// buffer read port once every PIX_DIV clocks and hands each head word to the
// head driver with a strobe. Owns both buffer ports exclusively.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : host stream + buffer read/write port (see interface)
//   line_go       : print trigger pulse, honoured only in READY
//   abort         : drop the current line and return to LOAD
//   prn_data      : registered head word {H4,H3,H2,H1}
//   prn_strobe    : prn_data valid, one-cycle pulse per read
//   line_busy     : high in READY, PRINT and DRAIN
//   line_done     : one-cycle pulse when the last head word has gone out
//   trig_miss     : one-cycle pulse when line_go arrived outside READY
// ---------------------------------------------------------------------------
module hn_line_sequencer #(
    parameter int WR_LEN  = 400,  // nibble writes per line, 2..1023
    parameter int RD_LEN  = 400,  // reads per line, 1..1023
    parameter int PIX_DIV = 4,    // clocks between read pulses, RD_LAT+1..255
    parameter int RD_LAT  = 2     // clocks from rden to PrnData, 1..4
) (
    input  logic                 clk,
    input  logic                 rst,
    hn_line_sequencer_if.slave   bus,
    input  logic                 line_go,
    input  logic                 abort,
    output logic [3:0]           prn_data,
    output logic                 prn_strobe,
    output logic                 line_busy,
    output logic                 line_done,
    output logic                 trig_miss
);

    localparam logic [9:0] WR_LAST  = 10'(WR_LEN - 1);
    localparam logic [9:0] RD_LAST  = 10'(RD_LEN - 1);
    localparam logic [7:0] DIV_LAST = 8'(PIX_DIV - 1);

    typedef enum logic [1:0] {
        LOAD,
        READY,
        PRINT,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [9:0]        wr_cnt;
    logic [9:0]        rd_cnt;
    logic [7:0]        div_cnt;
    logic [RD_LAT-1:0] strobe_sr;     // rden delayed by 1..RD_LAT clocks

    logic       wren_q, rden_q;
    logic [9:0] wraddress_q, rdaddress_q;
    logic [3:0] data_q, prn_data_q;
    logic       line_done_q, trig_miss_q;

    logic xfer;       // stream nibble accepted this cycle
    logic start;      // line_go honoured this cycle
    logic rd_issue;   // a read pulse is registered for the next cycle
    logic finish;     // final strobe is out, line completes
    logic capture;    // PrnData holds the word for the strobe due next cycle

    // -----------------------------------------------------------------------
    // Next-state and per-cycle control. abort is applied last so it wins
    // over everything the states decided.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_next = state;
        xfer       = 1'b0;
        start      = 1'b0;
        rd_issue   = 1'b0;
        finish     = 1'b0;

        case (state)
            LOAD: begin
                xfer = bus.s_valid;
                if (xfer && wr_cnt == WR_LAST) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (line_go) begin
                    start      = 1'b1;
                    rd_issue   = 1'b1;
                    state_next = PRINT;
                end
            end
            PRINT: begin
                // PIX_DIV >= 2, so the divider never wraps in a pulse cycle.
                rd_issue = (div_cnt == DIV_LAST);
                if (rden_q && rd_cnt == RD_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Only one read is ever in flight, so the next strobe is the last.
                if (prn_strobe) begin
                    finish     = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase

        if (abort) begin
            state_next = LOAD;
            xfer       = 1'b0;
            start      = 1'b0;
            rd_issue   = 1'b0;
            finish     = 1'b0;
        end
    end

    // The word for a strobe is sampled one edge before the strobe itself.
    if (RD_LAT == 1) begin : g_cap_direct
        assign capture = rden_q;
    end else begin : g_cap_pipe
        assign capture = strobe_sr[RD_LAT-2];
    end

    // -----------------------------------------------------------------------
    // State, counters and registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= LOAD;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            div_cnt     <= '0;
            strobe_sr   <= '0;
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
            wraddress_q <= '0;
            rdaddress_q <= '0;
            data_q      <= '0;
            prn_data_q  <= '0;
            line_done_q <= 1'b0;
            trig_miss_q <= 1'b0;
        end else begin
            state <= state_next;

            wren_q <= xfer;
            if (xfer) begin
                wraddress_q <= wr_cnt;
                data_q      <= bus.s_data;
            end

            rden_q <= rd_issue;
            if (rd_issue) begin
                rdaddress_q <= start ? '0 : rd_cnt;
            end

            line_done_q <= finish;
            trig_miss_q <= line_go && (state != READY);

            if (abort || finish) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                div_cnt <= '0;
            end else begin
                if (xfer) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
                if (start) begin
                    rd_cnt  <= '0;
                    div_cnt <= '0;
                end else if (state == PRINT) begin
                    div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                    if (rden_q && rd_cnt != RD_LAST) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
            end

            // abort flushes every read still in flight, including one issued this cycle.
            strobe_sr <= abort ? '0 : ((strobe_sr << 1) | RD_LAT'(rden_q));
            if (capture && !abort) begin
                prn_data_q <= bus.PrnData;
            end
        end
    end

    assign bus.s_ready   = (state == LOAD);
    assign bus.wren      = wren_q;
    assign bus.wraddress = wraddress_q;
    assign bus.data      = data_q;
    assign bus.rden      = rden_q;
    assign bus.rdaddress = rdaddress_q;

    assign prn_data   = prn_data_q;
    assign prn_strobe = strobe_sr[RD_LAT-1];
    assign line_busy  = (state != LOAD);
    assign line_done  = line_done_q;
    assign trig_miss  = trig_miss_q;

endmodule
